// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - score-driven square-wave tone sequencer
//
// Walks a synchronous score ROM of {note, dur} entries and plays each one as a
// square wave on the buzzer pin for (dur+1) duration ticks.
// Optional build macro: ARTICULATION_GAP_EN silences the final tick of every
// non-rest note.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   play         level: 1 = run/resume, 0 = pause
//   stop         pulse: abort, return to address 0
//   loop         level, sampled at end-of-score: 1 = restart at address 0
//   score_addr   ROM read address
//   score_data   ROM read data {note, dur}, one cycle after score_addr
//   buzzer       square-wave output, idle level 1
//   busy         high while not idle
//   done         one-cycle pulse at end-of-score in one-shot mode
module melody_sequencer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_DIV = 12_500_000,
    parameter int ADDR_W   = 9,
    parameter int NOTE_W   = 5,
    parameter int DUR_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    play,
    input  logic                    stop,
    input  logic                    loop,
    output logic [ADDR_W-1:0]       score_addr,
    input  logic [NOTE_W+DUR_W-1:0] score_data,
    output logic                    buzzer,
    output logic                    busy,
    output logic                    done
);

    localparam int HP_MAX = CLK_HZ / (2 * 262);
    localparam int HP_W   = $clog2(HP_MAX + 1);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NOTE_N = 2 ** NOTE_W;

    // Half-period in clk cycles for a note index; 0 marks a rest (or marker).
    function automatic int hp_calc(input int n);
        int f;
        f = 0;
        if (n >= 1 && n <= 21) begin
            case ((n - 1) % 7)
                0:       f = 262;
                1:       f = 294;
                2:       f = 330;
                3:       f = 349;
                4:       f = 392;
                5:       f = 440;
                default: f = 494;
            endcase
            f = f << ((n - 1) / 7);
        end
        return (f == 0) ? 0 : CLK_HZ / (2 * f);
    endfunction

    logic [HP_W-1:0] hp_tab [NOTE_N];
    for (genvar i = 0; i < NOTE_N; i++) begin : g_hp
        assign hp_tab[i] = HP_W'(hp_calc(i));
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_END} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [DUR_W-1:0]  tick_left;
    logic [TICK_W-1:0] tick_cnt;
    logic [HP_W-1:0]   hp_q;
    logic [HP_W-1:0]   tone_cnt;
    logic              buz_q;
    logic              done_q;

    logic [NOTE_W-1:0] ld_note;
    logic [DUR_W-1:0]  ld_dur;
    logic              is_end;
    logic              tick_wrap;
    logic              note_over;
    logic              gap_hold;

    assign ld_note   = score_data[NOTE_W+DUR_W-1:DUR_W];
    assign ld_dur    = score_data[DUR_W-1:0];
    assign is_end    = &ld_note;
    assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign note_over = tick_wrap && (tick_left == '0);

`ifdef ARTICULATION_GAP_EN
    // hp_q == 0 identifies a rest, which is silent anyway.
    assign gap_hold = (tick_left == '0) && (hp_q != '0);
`else
    assign gap_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // play=0 freezes FETCH/LOAD/PLAY; END resolves regardless of play.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (play) state_nxt = S_FETCH;
                S_FETCH: if (play) state_nxt = S_LOAD;
                S_LOAD:  if (play) state_nxt = is_end ? S_END : S_PLAY;
                S_PLAY:  if (play && note_over) state_nxt = S_FETCH;
                S_END:   state_nxt = loop ? S_FETCH : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != S_IDLE);
        score_addr = addr_q;
        done       = done_q;
        buzzer     = 1'b1;
        if (state == S_PLAY && play && !gap_hold) begin
            buzzer = buz_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            tick_left <= '0;
            tick_cnt  <= '0;
            hp_q      <= '0;
            tone_cnt  <= '0;
            buz_q     <= 1'b1;
            done_q    <= 1'b0;
        end else if (stop) begin
            addr_q    <= '0;
            tick_left <= '0;
            tick_cnt  <= '0;
            hp_q      <= '0;
            tone_cnt  <= '0;
            buz_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (play && !is_end) begin
                        tick_left <= ld_dur;
                        hp_q      <= hp_tab[ld_note];
                        tone_cnt  <= '0;
                        tick_cnt  <= '0;
                        buz_q     <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (play) begin
                        if (tick_wrap) begin
                            tick_cnt <= '0;
                            if (tick_left == '0) begin
                                addr_q <= addr_q + 1'b1;
                            end else begin
                                tick_left <= tick_left - 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                        if (gap_hold) begin
                            tone_cnt <= '0;
                        end else if (hp_q != '0) begin
                            if (tone_cnt == hp_q - 1'b1) begin
                                tone_cnt <= '0;
                                buz_q    <= ~buz_q;
                            end else begin
                                tone_cnt <= tone_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_END: begin
                    addr_q <= '0;
                    if (!loop) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - scoreboard bench for melody_sequencer
module tb_melody_sequencer;

    localparam int K_ADDR = 0;
    localparam int K_BUZ  = 1;
    localparam int K_DONE = 2;
    localparam int K_BUSY = 3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
        logic [31:0] cyc;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       play  = 1'b0;
    logic       stop  = 1'b0;
    logic       loop  = 1'b0;
    logic [8:0] score_addr;
    logic [8:0] score_data;
    logic       buzzer;
    logic       busy;
    logic       done;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    ev_t  sb[$];
    logic mon_en = 1'b0;
    logic [8:0] prev_addr = 9'd0;
    logic prev_buz  = 1'b1;
    logic prev_busy = 1'b0;
    logic [8:0] rom [512];

    melody_sequencer #(
        .CLK_HZ  (2_000_000),
        .TICK_DIV(100),
        .ADDR_W  (9),
        .NOTE_W  (5),
        .DUR_W   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .stop      (stop),
        .loop      (loop),
        .score_addr(score_addr),
        .score_data(score_data),
        .buzzer    (buzzer),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) score_data <= rom[score_addr];

    task automatic push(input int k, input int v, input int t);
        sb.push_back({2'(k), 16'(v), 32'(t)});
    endtask

    task automatic check_ev(input int k, input int v);
        ev_t got;
        ev_t exp_e;
        got = {2'(k), 16'(v), 32'(cyc)};
        if (sb.size() != 0) exp_e = sb.pop_front();
        else exp_e = '1;
        checks++;
        assert (got === exp_e) else begin
            errors++;
            $error("FAIL event got kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
                   got.kind, got.val, got.cyc, exp_e.kind, exp_e.val, exp_e.cyc);
        end
    endtask

    task automatic chk(input string tag, input int got, input int expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    // Resumes #1 after the posedge that makes cyc reach t.
    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_rom(input int n0, input int d0, input int n1,
                            input int d1, input int n2, input int d2);
        for (int i = 0; i < 512; i++) rom[i] = 9'h1F0;
        rom[0] = {5'(n0), 4'(d0)};
        rom[1] = {5'(n1), 4'(d1)};
        rom[2] = {5'(n2), 4'(d2)};
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (score_addr !== prev_addr) check_ev(K_ADDR, int'(score_addr));
            if (buzzer !== prev_buz) check_ev(K_BUZ, int'(buzzer));
            if (done !== 1'b0) check_ev(K_DONE, int'(done));
            if (busy !== prev_busy) check_ev(K_BUSY, int'(busy));
            prev_addr <= score_addr;
            prev_buz  <= buzzer;
            prev_busy <= busy;
        end
    end

    initial begin
        int c;
        int p;
        int q;

        load_rom(6, 1, 0, 0, 31, 0);
        at(3);
        chk("rst_buzzer", int'(buzzer), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(score_addr), 0);
        chk("rst_done", int'(done), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        at(5);

        // One-shot: note 6 for 200 cycles, rest for 100, then end marker.
        c = cyc;
        play = 1'b1;
        push(K_BUSY, 1, c + 1);
        push(K_ADDR, 1, c + 203);
        push(K_ADDR, 2, c + 305);
        push(K_ADDR, 0, c + 308);
        push(K_DONE, 1, c + 308);
        push(K_BUSY, 0, c + 308);
        at(c + 308);
        play = 1'b0;
        at(c + 315);
        chk("oneshot_drain", sb.size(), 0);

        // Looped: END returns to address 0, note 6 replays, no done pulse.
        c = cyc;
        loop = 1'b1;
        play = 1'b1;
        push(K_BUSY, 1, c + 1);
        push(K_ADDR, 1, c + 203);
        push(K_ADDR, 2, c + 305);
        push(K_ADDR, 0, c + 308);
        push(K_ADDR, 1, c + 510);
        at(c + 520);
        stop = 1'b1;
        play = 1'b0;
        push(K_ADDR, 0, c + 521);
        push(K_BUSY, 0, c + 521);
        at(c + 521);
        stop = 1'b0;
        loop = 1'b0;
        at(c + 525);
        chk("loop_drain", sb.size(), 0);

        // Pause 500 cycles mid-note; note 21 (HP 506) then note 14 (HP 1012).
        load_rom(21, 15, 14, 15, 31, 0);
        c = cyc;
        p = c + 3;
        play = 1'b1;
        push(K_BUSY, 1, c + 1);
        push(K_BUZ, 0, p + 506);
        at(p + 700);
        play = 1'b0;
        push(K_BUZ, 1, p + 700);
        at(p + 1200);
        play = 1'b1;
        push(K_BUZ, 0, p + 1200);
        push(K_BUZ, 1, p + 1512);
`ifdef ARTICULATION_GAP_EN
        push(K_ADDR, 1, p + 2100);
        push(K_BUZ, 0, p + 3114);
        push(K_BUZ, 1, p + 3602);
        push(K_ADDR, 2, p + 3702);
`else
        push(K_BUZ, 0, p + 2018);
        push(K_ADDR, 1, p + 2100);
        push(K_BUZ, 1, p + 2100);
        push(K_BUZ, 0, p + 3114);
        push(K_ADDR, 2, p + 3702);
        push(K_BUZ, 1, p + 3702);
`endif
        push(K_ADDR, 0, p + 3705);
        push(K_DONE, 1, p + 3705);
        push(K_BUSY, 0, p + 3705);
        at(p + 3705);
        play = 1'b0;
        at(p + 3710);
        chk("pause_drain", sb.size(), 0);

        // stop with play held: one idle cycle, restart from address 0.
        c = cyc;
        p = c + 3;
        play = 1'b1;
        push(K_BUSY, 1, c + 1);
        push(K_BUZ, 0, p + 506);
        at(p + 600);
        stop = 1'b1;
        push(K_BUZ, 1, p + 601);
        push(K_BUSY, 0, p + 601);
        push(K_BUSY, 1, p + 602);
        at(p + 601);
        stop = 1'b0;
        q = p + 604;
        push(K_BUZ, 0, q + 506);

        // Asynchronous reset mid-note with buzzer low.
        at(q + 800);
        push(K_BUZ, 1, q + 800);
        push(K_BUSY, 0, q + 800);
        rst_n = 1'b0;
        play  = 1'b0;
        #1;
        chk("async_rst_buzzer", int'(buzzer), 1);
        chk("async_rst_busy", int'(busy), 0);
        at(q + 803);
        rst_n = 1'b1;
        at(q + 808);
        chk("stop_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
